// File: rtl/decrypt_pkg.sv
// Shared encodings for the decryption run controller and its result reader.
// Values match the wrapper's cpu_en, wrstate and program-select pins.
package decrypt_pkg;

   localparam logic [1:0] CPU_IDLE  = 2'b00;
   localparam logic [1:0] CPU_WRITE = 2'b01;
   localparam logic [1:0] CPU_EXEC  = 2'b10;

   localparam logic [1:0] PROG_EN   = 2'b01;
   localparam logic [1:0] PROG_BF   = 2'b10;

   localparam logic [1:0] WR_IDLE   = 2'b00;
   localparam logic [1:0] WR_ACTIVE = 2'b10;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, RUN, DRAIN} state_t;

   function automatic logic prog_valid(input logic [1:0] prog);
      return (prog == PROG_EN) || (prog == PROG_BF);
   endfunction

endpackage

// File: rtl/result_reader.sv
// Streams len result bytes out of wrapper RAM with one read in flight at a time.
// The address is held until the handshake, so read_data stays stable while res_valid waits.
module result_reader
   import decrypt_pkg::*;
#(
   parameter int unsigned RES_BASE = 1500,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic [7:0]  read_data,
   input  logic        res_ready,
   output logic [11:0] read_addr,
   output logic        res_valid,
   output logic [7:0]  res_data,
   output logic        finished
);

   localparam int LAT_W = $clog2(RD_LAT + 2);

   logic             active;
   logic [7:0]       idx;
   logic [7:0]       len_q;
   logic [LAT_W-1:0] lat_cnt;
   logic             take;

   assign res_valid = active && (lat_cnt == LAT_W'(RD_LAT));
   assign res_data  = res_valid ? read_data : 8'd0;
   assign read_addr = active ? (12'(RES_BASE) + {4'd0, idx}) : 12'd0;
   assign take      = res_valid && res_ready;
   assign finished  = take && ((idx + 8'd1) == len_q);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         idx     <= '0;
         len_q   <= '0;
         lat_cnt <= '0;
      end else if (start) begin
         active  <= 1'b1;
         idx     <= '0;
         len_q   <= len;
         lat_cnt <= '0;
      end else if (active) begin
         if (take) begin
            if (finished) begin
               active <= 1'b0;
            end else begin
               idx     <= idx + 8'd1;
               lat_cnt <= '0;
            end
         end else if (lat_cnt != LAT_W'(RD_LAT)) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
         end
      end
   end

endmodule

// File: rtl/decrypt_run_ctrl.sv
// Job sequencer for the decryption processor wrapper: load chars, set shift, run, drain.
// Every output is decoded from registered state, so an async reset clears them at once.
module decrypt_run_ctrl
   import decrypt_pkg::*;
#(
   parameter int unsigned BUF_BASE = 1500,
   parameter int unsigned BUF_LEN  = 108,
   parameter int unsigned RES_BASE = 1500,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned TIMEOUT  = 2000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  prog_req,
   input  logic [4:0]  shift_req,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        res_valid,
   output logic [7:0]  res_data,
   input  logic        res_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  cpu_en,
   output logic [1:0]  wrstate,
   output logic [7:0]  curr_index,
   output logic [7:0]  char_buffer_data,
   output logic [4:0]  shift_amt_data,
   output logic [1:0]  program_sel,
   output logic [11:0] read_addr,
   input  logic        done_flag,
   input  logic [31:0] read_data
);

   localparam int CNT_W = ($clog2(TIMEOUT) > 21) ? $clog2(TIMEOUT) : 21;

   state_t           state, state_n;
   logic [7:0]       len;
   logic [1:0]       prog_q;
   logic [4:0]       shift_q;
   logic [CNT_W-1:0] run_cnt;
   logic             start_ok, start_bad, beat, load_end, timeout_hit;
   logic             rd_start, rd_finished;
   logic             unused_ok;

   // The wrapper adds the buffer base itself; only the upper RAM data byte lanes are unused.
   assign unused_ok = ^{read_data[31:8], 12'(BUF_BASE)};

   assign start_ok    = (state == IDLE) && start && prog_valid(prog_req);
   assign start_bad   = (state == IDLE) && start && !prog_valid(prog_req);
   assign in_ready    = (state == LOAD) && (len < 8'(BUF_LEN));
   assign beat        = in_valid && in_ready;
   assign load_end    = beat && (in_last || ((len + 8'd1) == 8'(BUF_LEN)));
   assign timeout_hit = (state == RUN) && !done_flag && (run_cnt == CNT_W'(TIMEOUT - 1));
   assign rd_start    = (state == RUN) && done_flag;
   assign busy        = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n          = state;
      cpu_en           = CPU_IDLE;
      wrstate          = WR_IDLE;
      curr_index       = 8'd0;
      char_buffer_data = 8'd0;
      shift_amt_data   = 5'd0;
      program_sel      = 2'b00;
      case (state)
         IDLE: begin
            if (start_ok) state_n = LOAD;
         end
         LOAD: begin
            cpu_en = CPU_WRITE;
            if (beat) begin
               wrstate          = WR_ACTIVE;
               curr_index       = len;
               char_buffer_data = in_data;
            end
            if (load_end) state_n = SHIFT;
         end
         SHIFT: begin
            // A zero shift drives nothing, leaving reg6 at its reset value.
            shift_amt_data = shift_q;
            program_sel    = prog_q;
            state_n        = RUN;
         end
         RUN: begin
            cpu_en      = CPU_EXEC;
            program_sel = prog_q;
            if (done_flag)        state_n = DRAIN;
            else if (timeout_hit) state_n = IDLE;
         end
         DRAIN: begin
            if (rd_finished) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         len     <= '0;
         prog_q  <= 2'b00;
         shift_q <= '0;
         run_cnt <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done    <= rd_finished;
         err     <= start_bad || timeout_hit;
         run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
         if (start_ok) begin
            prog_q  <= prog_req;
            shift_q <= shift_req;
            len     <= '0;
         end else if (beat) begin
            len <= len + 8'd1;
         end
      end
   end

   result_reader #(
      .RES_BASE (RES_BASE),
      .RD_LAT   (RD_LAT)
   ) u_reader (
      .clock     (clock),
      .reset     (reset),
      .start     (rd_start),
      .len       (len),
      .read_data (read_data[7:0]),
      .res_ready (res_ready),
      .read_addr (read_addr),
      .res_valid (res_valid),
      .res_data  (res_data),
      .finished  (rd_finished)
   );

endmodule

// File: tb/tb_decrypt_run_ctrl.sv
// Scoreboard bench: stimulus queues expected writes, shifts, result bytes and events;
// a negedge monitor pops and compares whenever the controller presents one.
module tb_decrypt_run_ctrl;
   import decrypt_pkg::*;

   localparam int BUF_BASE = 1500;
   localparam int BUF_LEN  = 108;
   localparam int RES_BASE = 1500;
   localparam int RD_LAT   = 1;
   localparam int TIMEOUT  = 100;

   logic        clock = 1'b0, reset;
   logic        start, in_valid, in_last, res_ready, done_flag;
   logic [1:0]  prog_req;
   logic [4:0]  shift_req;
   logic [7:0]  in_data;
   logic [31:0] read_data;
   logic        in_ready, res_valid, busy, done, err;
   logic [7:0]  res_data, curr_index, char_buffer_data;
   logic [1:0]  cpu_en, wrstate, program_sel;
   logic [4:0]  shift_amt_data;
   logic [11:0] read_addr;

   decrypt_run_ctrl #(
      .BUF_BASE(BUF_BASE), .BUF_LEN(BUF_LEN), .RES_BASE(RES_BASE),
      .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .prog_req(prog_req),
      .shift_req(shift_req), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .res_valid(res_valid),
      .res_data(res_data), .res_ready(res_ready), .busy(busy), .done(done),
      .err(err), .cpu_en(cpu_en), .wrstate(wrstate), .curr_index(curr_index),
      .char_buffer_data(char_buffer_data), .shift_amt_data(shift_amt_data),
      .program_sel(program_sel), .read_addr(read_addr), .done_flag(done_flag),
      .read_data(read_data)
   );

   always #5 clock = ~clock;

   logic [51:0] all_outs;
   assign all_outs = {in_ready, res_valid, res_data, busy, done, err, cpu_en, wrstate,
                      curr_index, char_buffer_data, shift_amt_data, program_sel, read_addr};

   logic [15:0] exp_wr[$];
   logic [4:0]  exp_shift[$];
   logic [7:0]  exp_res[$];
   int          exp_evt[$];    // 1 done, 2 timeout err, 3 bad-program err
   logic [7:0]  job_chars[$];
   logic [7:0]  mem [0:4095];
   logic [1:0]  exp_prog = 2'b00;
   int total = 0, bad = 0, cyc = 0, start_cyc = 0, run_start = 0, exp_len = 0, rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got=nothing/late want=expected item", name);
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Registered-read RAM: data for the address seen at an edge appears after that edge.
   initial forever begin
      @(posedge clock);
      read_data <= {24'h0, mem[read_addr]};
   end

   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0:       res_ready = ~res_ready;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b1;
         endcase
      end
   end

   initial begin
      logic        hold;
      logic [7:0]  held;
      logic [15:0] e;
      logic [1:0]  prev_en;
      int          res_idx, code, got;
      hold = 1'b0; held = 8'd0; prev_en = CPU_IDLE; res_idx = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold = 1'b0; res_idx = 0; prev_en = CPU_IDLE;
         end else begin
            if (wrstate == WR_ACTIVE) begin
               if (exp_wr.size() == 0) fail_now("wr_unexpected");
               else begin
                  e = exp_wr.pop_front();
                  check("wr_index", curr_index, e[15:8]);
                  check("wr_char", char_buffer_data, e[7:0]);
                  check("wr_cpu_en", cpu_en, CPU_WRITE);
               end
            end
            if (shift_amt_data != 5'd0) begin
               if (exp_shift.size() == 0) fail_now("shift_unexpected");
               else begin
                  check("shift_amt", shift_amt_data, exp_shift.pop_front());
                  check("shift_cpu_en", cpu_en, CPU_IDLE);
               end
            end
            if (cpu_en == CPU_EXEC && prev_en != CPU_EXEC) begin
               run_start = cyc;
               check("program_sel", program_sel, exp_prog);
            end
            prev_en = cpu_en;
            if (res_valid) begin
               if (hold) check("res_hold", res_data, held);
               if (res_ready) begin
                  if (exp_res.size() == 0) fail_now("res_unexpected");
                  else check("res_data", res_data, exp_res.pop_front());
                  check("read_addr", read_addr, RES_BASE + res_idx);
                  res_idx++;
                  hold = 1'b0;
               end else begin
                  hold = 1'b1;
                  held = res_data;
               end
            end
            if (done || err) begin
               got = done ? 1 : 2;
               if (exp_evt.size() == 0) fail_now("evt_unexpected");
               else begin
                  code = exp_evt.pop_front();
                  check("evt_kind", got, (code == 1) ? 1 : 2);
                  check("busy_after_evt", busy, 0);
                  check("cpu_en_after_evt", cpu_en, CPU_IDLE);
                  if (code == 1) begin
                     check("res_count", res_idx, exp_len);
                     check("res_left", exp_res.size(), 0);
                  end
                  if (code == 2) check("timeout_cycle", cyc - run_start, TIMEOUT);
                  if (code == 3) check("badprog_cycle", cyc - start_cyc, 1);
               end
               res_idx = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] p, input logic [4:0] s);
      prog_req = p; shift_req = s; start = 1'b1; start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic load_chars(input int n, input bit with_last);
      int n_acc;
      n_acc = with_last ? ((n < BUF_LEN) ? n : BUF_LEN) : BUF_LEN;
      for (int i = 0; i < n_acc; i++) exp_wr.push_back({8'(i), job_chars[i]});
      exp_len = n_acc;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = job_chars[i];
         in_last  = with_last && (i == n - 1);
         @(negedge clock);
         check("in_ready", in_ready, i < n_acc);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_exec();
      bit ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clock);
         if (cpu_en == CPU_EXEC) ok = 1'b1;
      end
      tick();
      if (!ok) fail_now("run_entry");
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(negedge clock);
         if (!busy) ok = 1'b1;
      end
      tick();
      if (!ok) fail_now("job_end");
      repeat (2) tick();
   endtask

   task automatic run_job(input logic [1:0] p, input logic [4:0] s, input int n,
                          input bit with_last, input bit hello, input int delay,
                          input bit poke, input bit timeout_job);
      logic [39:0] hs;
      hs = "HELLO";
      exp_prog = p;
      if (s != 5'd0) exp_shift.push_back(s);
      job_chars.delete();
      for (int i = 0; i < n; i++)
         job_chars.push_back(hello ? hs[39 - 8*i -: 8] : 8'($urandom_range(32, 126)));
      pulse_start(p, s);
      load_chars(n, with_last);
      wait_exec();
      if (poke) begin
         prog_req = 2'b00; start = 1'b1;
         tick();
         start = 1'b0;
      end
      if (timeout_job) begin
         exp_evt.push_back(2);
         wait_idle(TIMEOUT + 20);
      end else begin
         repeat (delay) tick();
         for (int i = 0; i < exp_len; i++) begin
            mem[RES_BASE + i] = hello ? 8'(8'h41 + i) : 8'($urandom);
            exp_res.push_back(mem[RES_BASE + i]);
         end
         exp_evt.push_back(1);
         done_flag = 1'b1;
         tick();
         done_flag = 1'b0;
         wait_idle(exp_len * 8 + 50);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got=still running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
      reset = 1'b1; start = 1'b0; prog_req = 2'b00; shift_req = 5'd0;
      in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; done_flag = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("outs_in_reset", all_outs, 52'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("outs_after_reset", all_outs, 52'd0);
      tick();

      rdy_mode = 0;
      run_job(PROG_EN, 5'd3, 5, 1'b1, 1'b1, 48, 1'b1, 1'b0);

      rdy_mode = 1;
      run_job(PROG_BF, 5'd7, 110, 1'b0, 1'b0, 10, 1'b0, 1'b0);

      run_job(PROG_BF, 5'd0, 4, 1'b1, 1'b0, 0, 1'b0, 1'b1);

      for (int b = 0; b < 2; b++) begin
         exp_evt.push_back(3);
         pulse_start((b == 0) ? 2'b00 : 2'b11, 5'd5);
         repeat (3) begin
            @(negedge clock);
            check("no_load", busy, 0);
            tick();
         end
      end

      exp_prog = PROG_EN;
      exp_shift.push_back(5'd9);
      job_chars.delete();
      for (int i = 0; i < 3; i++) job_chars.push_back(8'($urandom_range(65, 90)));
      pulse_start(PROG_EN, 5'd9);
      load_chars(3, 1'b1);
      wait_exec();
      repeat (5) tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outs", all_outs, 52'd0);
      tick();
      reset = 1'b0;
      check("wr_after_reset", exp_wr.size(), 0);
      check("shift_after_reset", exp_shift.size(), 0);
      tick();

      for (int j = 0; j < 4; j++) begin
         rdy_mode = (j % 2 == 0) ? 1 : 2;
         run_job(($urandom_range(0, 1) == 0) ? PROG_EN : PROG_BF, 5'($urandom_range(0, 31)),
                 $urandom_range(1, 24), 1'b1, 1'b0, $urandom_range(0, 40), 1'b0, 1'b0);
      end

      check("evt_left", exp_evt.size(), 0);
      check("res_left_end", exp_res.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decrypt_run_ctrl.md
Name: decrypt_run_ctrl

Overview:
Sequencer for the decryption processor wrapper: one job is one pass through a fixed flow.
- Stream ciphertext characters into the processor RAM character buffer.
- Load the shift amount into register 6 and select the EN or BF program.
- Run the CPU until register 28 is written with 1 (done flag).
- Stream the result bytes back out of RAM.
It drives the wrapper's cpu_en, wrstate, curr_index, char_buffer_data, shift_amt_data, program_sel and read_addr pins. It sits between the UART/keypad front-end and the wrapper.

Parameters:
BUF_BASE, 1500, RAM word address of character buffer index 0
BUF_LEN, 108, maximum characters per job (12x9 display)
RES_BASE, 1500, RAM word address of first result byte
RD_LAT, 1, RAM read latency in clocks in the idle/read mode
TIMEOUT, 2000000, max RUN cycles before error abort

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; accepted only in IDLE
prog_req  in  2  01=EN, 10=BF; sampled with start
shift_req  in  5  shift amount; sampled with start
in_valid  in  1  input char valid
in_data  in  8  input char
in_last  in  1  marks final input char
in_ready  out  1  controller accepts char this cycle
res_valid  out  1  result byte valid
res_data  out  8  result byte
res_ready  in  1  downstream accepts result byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, job completed normally
err  out  1  one-cycle pulse, timeout abort
cpu_en  out  2  00 idle, 01 write, 10 exec
wrstate  out  2  10 on a char write cycle, else 00
curr_index  out  8  buffer write index
char_buffer_data  out  8  char to write
shift_amt_data  out  5  nonzero for exactly one cycle to load reg6
program_sel  out  2  program ROM select, held through RUN
read_addr  out  12  RAM read address in idle mode
done_flag  in  1  wrapper read_regA[0] (reg28 written with 1)
read_data  in  32  wrapper RAM read data

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; length counter 0.

IDLE:
- in_ready=0.
- On start: latch prog_req/shift_req, clear len, go to LOAD.
- If prog_req is not 01 or 10: pulse err next cycle, stay IDLE.

LOAD:
- cpu_en=01; in_ready=1 while len<BUF_LEN.
- On in_valid&in_ready, same cycle: wrstate=10, curr_index=len, char_buffer_data=in_data. Then len+=1.
- Leave to SHIFT after the in_last beat, or after the beat that makes len==BUF_LEN. The extra char is not accepted; in_ready drops.
- Char at index k lands at RAM BUF_BASE+k.

SHIFT:
- One cycle, cpu_en=00, shift_amt_data=latched shift.
- Shift 0 skips the write: reg6 keeps its reset value of 0.
- Next state RUN.

RUN:
- cpu_en=10; program_sel=latched program.
- Cycle counter counts from 0.
- On done_flag=1: go to DRAIN.
- If counter reaches TIMEOUT-1 first: pulse err, go to IDLE.

DRAIN:
- cpu_en=00; read_addr=RES_BASE+idx, idx 0..len-1.
- Issue an address, wait RD_LAT cycles, then present res_valid=1 with res_data=read_data[7:0].
- Hold res_valid and res_data stable until res_ready.
- At most one outstanding read: the next address is issued only after the handshake.
- After byte len-1 is accepted: pulse done, go to IDLE.
- len==0 (in_last never seen is impossible): a job with 0 chars goes LOAD→SHIFT only via in_last, so len is always ≥1.

General rules:
- start in any non-IDLE state is ignored.
- done_flag outside RUN is ignored.
- Reset mid-job returns to IDLE with cpu_en=00 immediately (async). Wrapper RAM contents are undefined afterwards.
- Counters are unsigned. idx and len are 8-bit; the run counter is wide enough for TIMEOUT (≥21 bits).

Decomposition:
Shared package decrypt_pkg holds:
- cpu_en encodings CPU_IDLE=00, CPU_WRITE=01, CPU_EXEC=10.
- Program encodings PROG_EN=01, PROG_BF=10.
- WR_ACTIVE=10.
- State enum {IDLE, LOAD, SHIFT, RUN, DRAIN}.

One natural sub-module is result_reader: DRAIN address issue, RD_LAT delay and valid/ready hold. It takes start and len, and returns a finished pulse.

Test Plan:
- Reset then start(prog=01, shift=3) and 5 chars "HELLO" with in_last on 'O' → wrstate=10 on 5 cycles with curr_index 0..4; shift_amt_data=3 for exactly 1 cycle; cpu_en=10 with program_sel=01.
- Hold in_valid for 110 chars, no in_last → exactly 108 accepted (curr_index max 107); in_ready=0 on the 109th char; state advances to SHIFT.
- In RUN, assert done_flag after 50 cycles; RAM model returns 0x41+idx; res_ready toggles every other cycle → 5 bytes 0x41..0x45 in order, each held stable while res_ready=0; done pulses once.
- prog_req=10 with done_flag never asserted, TIMEOUT=100 → err pulse at RUN cycle 100; cpu_en returns to 00; busy=0.
- Assert reset while in RUN → cpu_en=00 and all outputs 0 in the same cycle with no clock edge; the next start works normally.
- start with prog_req=00 → err pulse and no LOAD; start pulsed during RUN → no effect.
